capture_sequencer: RTL and testbench
====================================

# capture_sequencer

- Front-end controller ahead of the Bayer-to-RGB converter.
- Takes camera frame/line-valid strobes and raw pixels; sequences capture via start/stop/snapshot commands.
- Produces the gated pixel stream with column/row counters (oX_Cont/oY_Cont) that drive the converter's row FIFO and phase logic.
- Counts completed frames and flags lines longer than the row FIFO.

## Interface
- MAX_COLS, 2048: row FIFO depth; maximum accepted pixels per line.
- CNT_W, 11: width of column/row counters.
- iCLK  in  1  pixel clock
- iRST  in  1  reset, asynchronous, active-low
- iFVAL  in  1  camera frame valid
- iLVAL  in  1  camera line valid
- iDATA  in  12  raw Bayer pixel
- iStart  in  1  pulse: continuous capture
- iSnap  in  1  pulse: capture exactly one frame
- iStop  in  1  pulse: stop after current frame
- oDATA  out  12  registered pixel
- oDVAL  out  1  pixel valid
- oX_Cont  out  CNT_W  column of oDATA
- oY_Cont  out  CNT_W  row of oDATA
- oFrame_Cont  out  32  completed frames since reset
- oFrame_done  out  1  one-cycle pulse at end of a captured frame
- oBusy  out  1  state != IDLE
- oOverflow  out  1  sticky: line exceeded MAX_COLS

## Operation
- States: IDLE, SYNC (wait iFVAL low), WAIT_FRAME (wait iFVAL rising), ACTIVE.
- IDLE:
  - iStart or iSnap -> SYNC.
  - Clears oOverflow.
  - Latches snap mode (iSnap=1) or continuous mode.
- SYNC: iFVAL=0 -> WAIT_FRAME. Never starts mid-frame.
- WAIT_FRAME: iFVAL rising (iFVAL=1, previous sample 0) -> ACTIVE in the same cycle; row=0, col=0.
- ACTIVE, pixel accepted when iFVAL&iLVAL=1:
  - col < MAX_COLS: oDVAL=1, col++.
  - col = MAX_COLS: pixel dropped, oOverflow set.
- ACTIVE, iLVAL falling: col=0; row++, saturating at 2^CNT_W-1.
- ACTIVE, iFVAL falling:
  - oFrame_done=1; oFrame_Cont++ (wraps at 2^32).
  - Go to IDLE if snap mode or stop pending (stop pending then cleared).
  - Otherwise go to WAIT_FRAME.
- iStop:
  - In SYNC or WAIT_FRAME: -> IDLE next cycle.
  - In ACTIVE: sets stop pending.
  - In IDLE: ignored.
- Priority within one cycle: iStop > iSnap > iStart. iStart/iSnap outside IDLE are ignored.
- oX_Cont/oY_Cont hold their last values while oDVAL=0. oDATA follows iDATA every cycle.

## Timing
- Reset values: all outputs 0; state IDLE; stop pending and snap mode 0; edge-detect registers 0.
- Latency: input pixel at cycle n -> oDATA/oDVAL/oX_Cont/oY_Cont at n+1, all registered.
- The frame-start pixel (cycle of iFVAL rising with iLVAL=1) is accepted as row 0, col 0.
- oFrame_done asserts at n+1 for iFVAL falling at n. oFrame_Cont updates in the same cycle.
- iFVAL falling while iLVAL=1 ends both line and frame. The row increment is discarded; next frame starts at row 0.
- Async reset mid-frame: outputs clear immediately. After release, capture needs a new iStart and re-syncs through SYNC.
- Command pulses are single-cycle, synchronous to iCLK. Held levels act as repeated pulses.

## Structure
- Package capture_pkg holds:
  - state enum (IDLE=2'd0, SYNC=2'd1, WAIT_FRAME=2'd2, ACTIVE=2'd3);
  - MAX_COLS and CNT_W defaults;
  - pixel width constant 12.
- One sub-module, capture_edge_detect: registers iFVAL/iLVAL and emits rise/fall pulses for both. Reused by later camera blocks.
- FSM, counters and output registers live in the top module.

## Test plan
- Reset, then 2 frames of 4 lines x 8 pixels, no command -> oDVAL never 1, oFrame_Cont=0, oBusy=0.
- iStart while iFVAL=1 mid-frame -> that frame is skipped. Next frame yields 32 oDVAL pulses with X 0..7 and Y 0..3, each 1 cycle after the input. oFrame_Cont=1.
- iSnap, 3 frames sent -> exactly 1 frame captured; oFrame_done once; return to IDLE; oFrame_Cont=1.
- iStop at line 2 of continuous capture -> rest of that frame delivered through Y=3, then IDLE. Following frame ignored.
- MAX_COLS=8, line of 10 pixels -> 8 valid pixels X 0..7, 2 dropped, oOverflow=1 until next iStart.
- iStart, iSnap and iStop in the same cycle while IDLE -> stays IDLE. Async reset mid-line -> all outputs 0 at once, no oDVAL until a fresh iStart and frame edge.

Source files
------------

// File: rtl/capture_sequencer_pkg.sv
// Shared types and defaults for the camera capture front end.
package capture_pkg;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SYNC       = 2'd1,
    WAIT_FRAME = 2'd2,
    ACTIVE     = 2'd3
  } cap_state_t;

  localparam int MAX_COLS_DEF = 2048;
  localparam int CNT_W_DEF    = 11;
  localparam int PIX_W        = 12;
endpackage

// File: rtl/capture_sequencer_edge_detect.sv
// Registers the camera frame/line strobes and flags their rising and falling edges.
module capture_edge_detect (
  input  logic iCLK,
  input  logic iRST,
  input  logic iFVAL,
  input  logic iLVAL,
  output logic o_fval_rise,
  output logic o_fval_fall,
  output logic o_lval_rise,
  output logic o_lval_fall
);
  logic r_fval_d;
  logic r_lval_d;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_fval_d <= 1'b0;
      r_lval_d <= 1'b0;
    end else begin
      r_fval_d <= iFVAL;
      r_lval_d <= iLVAL;
    end
  end

  assign o_fval_rise = iFVAL & ~r_fval_d;
  assign o_fval_fall = ~iFVAL & r_fval_d;
  assign o_lval_rise = iLVAL & ~r_lval_d;
  assign o_lval_fall = ~iLVAL & r_lval_d;
endmodule

// File: rtl/capture_sequencer.sv
// Capture sequencer: gates raw camera pixels into frames on command and tracks
// column/row position, frame count and over-long lines.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int MAX_COLS = MAX_COLS_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iFVAL,
  input  logic             iLVAL,
  input  logic [PIX_W-1:0] iDATA,
  input  logic             iStart,
  input  logic             iSnap,
  input  logic             iStop,
  output logic [PIX_W-1:0] oDATA,
  output logic             oDVAL,
  output logic [CNT_W-1:0] oX_Cont,
  output logic [CNT_W-1:0] oY_Cont,
  output logic [31:0]      oFrame_Cont,
  output logic             oFrame_done,
  output logic             oBusy,
  output logic             oOverflow
);
  // Column counter must be able to hold MAX_COLS itself to detect the overflow pixel.
  localparam int COL_W = $clog2(MAX_COLS + 1);
  localparam logic [COL_W-1:0] COL_LIM = COL_W'(MAX_COLS);
  localparam logic [CNT_W-1:0] ROW_MAX = '1;

  cap_state_t       r_state;
  logic             r_snap;
  logic             r_stop_pend;
  logic [COL_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;

  logic             w_fval_rise;
  logic             w_fval_fall;
  logic             w_lval_rise;
  logic             w_lval_fall;
  logic [COL_W-1:0] w_col;

  capture_edge_detect u_edge (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iFVAL       (iFVAL),
    .iLVAL       (iLVAL),
    .o_fval_rise (w_fval_rise),
    .o_fval_fall (w_fval_fall),
    .o_lval_rise (w_lval_rise),
    .o_lval_fall (w_lval_fall)
  );

  // A new line always starts at column 0, even if the previous one never closed cleanly.
  assign w_col = w_lval_rise ? '0 : r_col;
  assign oBusy = (r_state != IDLE);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state     <= IDLE;
      r_snap      <= 1'b0;
      r_stop_pend <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
      oDATA       <= '0;
      oDVAL       <= 1'b0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
      oFrame_Cont <= '0;
      oFrame_done <= 1'b0;
      oOverflow   <= 1'b0;
    end else begin
      oDATA       <= iDATA;
      oDVAL       <= 1'b0;
      oFrame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!iStop && (iSnap || iStart)) begin
            r_state   <= SYNC;
            r_snap    <= iSnap;
            oOverflow <= 1'b0;
          end
        end
        SYNC: begin
          if (iStop)       r_state <= IDLE;
          else if (!iFVAL) r_state <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (iStop) begin
            r_state <= IDLE;
          end else if (w_fval_rise) begin
            r_state <= ACTIVE;
            r_row   <= '0;
            r_col   <= '0;
            if (iLVAL) begin
              oDVAL   <= 1'b1;
              oX_Cont <= '0;
              oY_Cont <= '0;
              r_col   <= COL_W'(1);
            end
          end
        end
        ACTIVE: begin
          if (w_fval_fall) begin
            // Frame end also closes any open line; its row increment is dropped.
            oFrame_done <= 1'b1;
            oFrame_Cont <= oFrame_Cont + 32'd1;
            r_stop_pend <= 1'b0;
            r_state     <= (r_snap || r_stop_pend || iStop) ? IDLE : WAIT_FRAME;
          end else begin
            if (iStop) r_stop_pend <= 1'b1;
            if (iFVAL && iLVAL) begin
              if (w_col < COL_LIM) begin
                oDVAL   <= 1'b1;
                oX_Cont <= CNT_W'(w_col);
                oY_Cont <= r_row;
                r_col   <= w_col + 1'b1;
              end else begin
                oOverflow <= 1'b1;
              end
            end else if (w_lval_fall) begin
              r_col <= '0;
              if (r_row != ROW_MAX) r_row <= r_row + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer: stimulus queues expected pixels, a
// negedge monitor pops and compares whenever oDVAL is seen.
module tb_capture_sequencer;
  import capture_pkg::*;

  localparam int MAXC = 8;
  localparam int CW   = 11;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b1;
  logic          iFVAL = 1'b0;
  logic          iLVAL = 1'b0;
  logic [11:0]   iDATA = '0;
  logic          iStart = 1'b0;
  logic          iSnap = 1'b0;
  logic          iStop = 1'b0;
  logic [11:0]   oDATA;
  logic          oDVAL;
  logic [CW-1:0] oX_Cont;
  logic [CW-1:0] oY_Cont;
  logic [31:0]   oFrame_Cont;
  logic          oFrame_done;
  logic          oBusy;
  logic          oOverflow;

  capture_sequencer #(.MAX_COLS(MAXC), .CNT_W(CW)) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iFVAL       (iFVAL),
    .iLVAL       (iLVAL),
    .iDATA       (iDATA),
    .iStart      (iStart),
    .iSnap       (iSnap),
    .iStop       (iStop),
    .oDATA       (oDATA),
    .oDVAL       (oDVAL),
    .oX_Cont     (oX_Cont),
    .oY_Cont     (oY_Cont),
    .oFrame_Cont (oFrame_Cont),
    .oFrame_done (oFrame_done),
    .oBusy       (oBusy),
    .oOverflow   (oOverflow)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [11:0]   data;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    int            stamp;
  } pix_t;

  pix_t sb[$];
  pix_t exp_px;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  always @(negedge iCLK) begin
    if (oFrame_done === 1'b1) done_cnt++;
    if (oDVAL === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL pixel_unexpected: got oDVAL=1 data=%h x=%0d y=%0d, required oDVAL=0",
                 oDATA, oX_Cont, oY_Cont);
      end else begin
        exp_px = sb.pop_front();
        if (oDATA !== exp_px.data || oX_Cont !== exp_px.x || oY_Cont !== exp_px.y ||
            cyc != exp_px.stamp + 1) begin
          n_err++;
          $display("FAIL pixel: got data=%h x=%0d y=%0d cyc=%0d, required data=%h x=%0d y=%0d cyc=%0d",
                   oDATA, oX_Cont, oY_Cont, cyc, exp_px.data, exp_px.x, exp_px.y, exp_px.stamp + 1);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic push(input logic [11:0] d, input int x, input int y);
    pix_t t;
    t.data  = d;
    t.x     = CW'(x);
    t.y     = CW'(y);
    t.stamp = cyc;
    sb.push_back(t);
  endtask

  task automatic cmd(input logic s, input logic sn, input logic st);
    iStart = s; iSnap = sn; iStop = st;
    tick();
    iStart = 1'b0; iSnap = 1'b0; iStop = 1'b0;
  endtask

  // lead=0 makes iFVAL and iLVAL rise together (frame-start pixel case).
  task automatic send_frame(input int tag, input int nl, input int np, input bit lead,
                            input bit cap, input int cmd_l,
                            input logic cs, input logic csn, input logic cst);
    iFVAL = 1'b1;
    if (lead) begin iLVAL = 1'b0; tick(); end
    for (int l = 0; l < nl; l++) begin
      for (int p = 0; p < np; p++) begin
        iLVAL = 1'b1;
        iDATA = 12'((tag << 8) | (l << 4) | p);
        if (l == cmd_l && p == 0) begin iStart = cs; iSnap = csn; iStop = cst; end
        if (cap && p < MAXC) push(iDATA, p, l);
        tick();
        iStart = 1'b0; iSnap = 1'b0; iStop = 1'b0;
      end
      iLVAL = 1'b0;
      tick();
      tick();
    end
    iFVAL = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #2 iRST = 1'b0;
    #1;
    chk("rst_dval", oDVAL, 0);
    chk("rst_data", oDATA, 0);
    chk("rst_x", oX_Cont, 0);
    chk("rst_y", oY_Cont, 0);
    chk("rst_frames", oFrame_Cont, 0);
    chk("rst_done", oFrame_done, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_ovf", oOverflow, 0);
    tick(); tick();
    iRST = 1'b1;
    tick();

    // Frames with no command are ignored.
    send_frame(1, 4, 8, 1, 0, -1, 0, 0, 0);
    send_frame(2, 4, 8, 1, 0, -1, 0, 0, 0);
    chk("idle_frames", oFrame_Cont, 0);
    chk("idle_busy", oBusy, 0);
    chk("idle_done", done_cnt, 0);

    // Start mid-frame: that frame skipped, next one captured from frame-start pixel.
    send_frame(3, 4, 8, 1, 0, 1, 1, 0, 0);
    chk("start_busy", oBusy, 1);
    send_frame(4, 4, 8, 0, 1, -1, 0, 0, 0);
    chk("start_frames", oFrame_Cont, 1);
    chk("start_done", done_cnt, 1);
    chk("start_busy2", oBusy, 1);
    chk("start_ovf", oOverflow, 0);
    chk("start_sb", sb.size(), 0);
    cmd(0, 0, 1);
    chk("stop_wait_busy", oBusy, 0);

    // Snapshot: exactly one of three frames.
    cmd(0, 1, 0); tick();
    send_frame(5, 4, 8, 1, 1, -1, 0, 0, 0);
    chk("snap_busy", oBusy, 0);
    send_frame(6, 4, 8, 1, 0, -1, 0, 0, 0);
    send_frame(7, 4, 8, 1, 0, -1, 0, 0, 0);
    chk("snap_frames", oFrame_Cont, 2);
    chk("snap_done", done_cnt, 2);
    chk("snap_sb", sb.size(), 0);

    // Stop during line 2: rest of frame delivered, next frame ignored.
    cmd(1, 0, 0); tick();
    send_frame(8, 4, 8, 1, 1, 2, 0, 0, 1);
    send_frame(9, 4, 8, 1, 0, -1, 0, 0, 0);
    chk("stop_frames", oFrame_Cont, 3);
    chk("stop_busy", oBusy, 0);
    chk("stop_done", done_cnt, 3);
    chk("stop_sb", sb.size(), 0);

    // Over-long line: 8 accepted, 2 dropped, sticky flag until next start.
    cmd(1, 0, 0); tick();
    send_frame(10, 1, 10, 1, 1, -1, 0, 0, 0);
    chk("ovf_flag", oOverflow, 1);
    chk("ovf_frames", oFrame_Cont, 4);
    chk("ovf_sb", sb.size(), 0);
    cmd(0, 0, 1);
    chk("ovf_hold", oOverflow, 1);
    chk("ovf_idle", oBusy, 0);
    cmd(1, 0, 0);
    chk("ovf_clear", oOverflow, 0);
    cmd(0, 0, 1);
    chk("ovf_stop", oBusy, 0);

    // All three commands together: stop wins, stays idle.
    cmd(1, 1, 1);
    chk("all_cmd_busy", oBusy, 0);
    send_frame(11, 2, 8, 1, 0, -1, 0, 0, 0);
    chk("all_cmd_frames", oFrame_Cont, 4);

    // Asynchronous reset mid-line.
    cmd(1, 0, 0); tick();
    iFVAL = 1'b1; iLVAL = 1'b1;
    iDATA = 12'hC00; push(iDATA, 0, 0); tick();
    iDATA = 12'hC01; push(iDATA, 1, 0); tick();
    @(negedge iCLK); #1;
    iRST = 1'b0;
    #1;
    chk("arst_dval", oDVAL, 0);
    chk("arst_data", oDATA, 0);
    chk("arst_x", oX_Cont, 0);
    chk("arst_frames", oFrame_Cont, 0);
    chk("arst_busy", oBusy, 0);
    @(posedge iCLK); #1;
    iRST = 1'b1;
    for (int p = 2; p < 8; p++) begin iDATA = 12'(12'hC00 | p); tick(); end
    iLVAL = 1'b0; tick();
    iFVAL = 1'b0; repeat (4) tick();
    send_frame(13, 2, 8, 1, 0, -1, 0, 0, 0);
    chk("arst_no_restart", oFrame_Cont, 0);
    cmd(1, 0, 0); tick();
    send_frame(14, 2, 8, 1, 1, -1, 0, 0, 0);
    chk("arst_frames2", oFrame_Cont, 1);
    chk("arst_done", done_cnt, 5);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
